// File: rtl/rgbw_pkg.sv
// Shared opcodes, channel indices and FSM states for the RGBW frame decoder.
package rgbw_pkg;

  localparam logic [3:0] OP_WR_CH  = 4'h1;
  localparam logic [3:0] OP_WR_ALL = 4'h2;
  localparam logic [3:0] OP_WR_INT = 4'h3;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_W = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    CHECK,
    DONE,
    ERR
  } state_t;

  function automatic logic op_known(input logic [3:0] op);
    return (op == OP_WR_CH) || (op == OP_WR_ALL) || (op == OP_WR_INT);
  endfunction

  function automatic logic [2:0] payload_len(input logic [3:0] op);
    return (op == OP_WR_ALL) ? 3'd4 : 3'd1;
  endfunction

endpackage

// File: rtl/rgbw_frame_decoder.sv
// Decodes checksummed command frames from the SPI byte stream and commits RGBW
// duties / intensity atomically; one frame per cs-low window, no backpressure.
module rgbw_frame_decoder
  import rgbw_pkg::*;
#(
  parameter logic [7:0] INTENSITY_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic [7:0] duty_w,
  output logic [7:0] intensity,
  output logic       update,
  output logic       frame_err
);

  state_t      state, state_nxt;
  logic        cs_q;
  logic [3:0]  op_q;
  logic [1:0]  ch_q;
  logic [7:0]  acc;
  logic [2:0]  idx;
  logic [7:0]  shadow_duty [4];
  logic [7:0]  shadow_int;
  logic [7:0]  duty_q [4];

  logic        strobe;
  logic        latch_cmd;
  logic        store_pl;
  logic        commit;
  logic        err_set;

  // cs high wins over a coincident strobe
  assign strobe = byte_valid & ~cs;

  always_comb begin
    state_nxt = state;
    latch_cmd = 1'b0;
    store_pl  = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    if (cs) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        // only a real falling edge of cs opens a window, so a reset released
        // mid-window never picks up the tail of an old frame
        IDLE: begin
          if (cs_q) state_nxt = CMD;
        end
        CMD: begin
          if (strobe) begin
            latch_cmd = 1'b1;
            if (op_known(byte_data[7:4])) begin
              state_nxt = PAYLOAD;
            end else begin
              state_nxt = ERR;
              err_set   = 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (strobe) begin
            store_pl = 1'b1;
            if (idx + 3'd1 == payload_len(op_q)) state_nxt = CHECK;
          end
        end
        CHECK: begin
          if (strobe) begin
            if (byte_data == acc) commit = 1'b1;
            else                  err_set = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE, ERR: state_nxt = state;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cs_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cs_q  <= cs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= 4'h0;
      ch_q       <= 2'd0;
      acc        <= 8'h00;
      idx        <= 3'd0;
      shadow_int <= 8'h00;
      for (int i = 0; i < 4; i++) shadow_duty[i] <= 8'h00;
    end else if (latch_cmd) begin
      op_q <= byte_data[7:4];
      ch_q <= byte_data[1:0];
      acc  <= byte_data;
      idx  <= 3'd0;
    end else if (store_pl) begin
      acc <= acc ^ byte_data;
      idx <= idx + 3'd1;
      case (op_q)
        OP_WR_CH:  shadow_duty[ch_q]     <= byte_data;
        OP_WR_ALL: shadow_duty[idx[1:0]] <= byte_data;
        default:   shadow_int            <= byte_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intensity <= INTENSITY_RST;
      update    <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 4; i++) duty_q[i] <= 8'h00;
    end else begin
      update    <= commit;
      frame_err <= err_set;
      if (commit) begin
        case (op_q)
          OP_WR_CH:  duty_q[ch_q] <= shadow_duty[ch_q];
          OP_WR_ALL: for (int i = 0; i < 4; i++) duty_q[i] <= shadow_duty[i];
          default:   intensity <= shadow_int;
        endcase
      end
    end
  end

  assign duty_r = duty_q[CH_R];
  assign duty_g = duty_q[CH_G];
  assign duty_b = duty_q[CH_B];
  assign duty_w = duty_q[CH_W];

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Directed and random frames checked against a frame-level reference model.
module tb_rgbw_frame_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [7:0] duty_r, duty_g, duty_b, duty_w, intensity;
  logic       update, frame_err;

  rgbw_frame_decoder #(.INTENSITY_RST(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .duty_r     (duty_r),
    .duty_g     (duty_g),
    .duty_b     (duty_b),
    .duty_w     (duty_w),
    .intensity  (intensity),
    .update     (update),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0] exp_duty [4];
  logic [7:0] exp_int;
  int         exp_upd = 0;
  int         exp_err = 0;
  logic [7:0] win [$];

  int upd_seen = 0;
  int err_seen = 0;
  always @(negedge clk) begin
    if (update)    upd_seen++;
    if (frame_err) err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the frame rules to all bytes seen in one cs-low window.
  task automatic model_window();
    logic [3:0] op;
    int         len;
    logic [7:0] x;
    if (win.size() == 0) return;
    op = win[0][7:4];
    if (!(op inside {4'h1, 4'h2, 4'h3})) begin
      exp_err++;
      return;
    end
    len = (op == 4'h2) ? 4 : 1;
    if (win.size() < len + 2) return;
    x = 8'h00;
    for (int i = 0; i <= len; i++) x ^= win[i];
    if (win[len+1] != x) begin
      exp_err++;
    end else begin
      exp_upd++;
      case (op)
        4'h1:    exp_duty[win[0][1:0]] = win[1];
        4'h2:    for (int c = 0; c < 4; c++) exp_duty[c] = win[1+c];
        default: exp_int = win[1];
      endcase
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    if (!cs) win.push_back(b);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic window_begin();
    @(negedge clk);
    cs = 1'b0;
    win.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic window_end();
    @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    model_window();
    win.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".duty_r"},    duty_r,    exp_duty[0]);
    chk({tag, ".duty_g"},    duty_g,    exp_duty[1]);
    chk({tag, ".duty_b"},    duty_b,    exp_duty[2]);
    chk({tag, ".duty_w"},    duty_w,    exp_duty[3]);
    chk({tag, ".intensity"}, intensity, exp_int);
    chk({tag, ".updates"},   upd_seen,  exp_upd);
    chk({tag, ".errors"},    err_seen,  exp_err);
  endtask

  task automatic send_list(input logic [7:0] q [$]);
    foreach (q[i]) send_byte(q[i], 0);
  endtask

  initial begin
    logic [7:0] fr [$];
    logic [3:0] op;
    logic [7:0] x;
    int         kind, v;

    for (int c = 0; c < 4; c++) exp_duty[c] = 8'h00;
    exp_int    = 8'hFF;
    reset      = 1'b1;
    cs         = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.update", update, 1'b0);
    chk("reset.frame_err", frame_err, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single channel write to G, commit exactly one edge after the checksum
    window_begin();
    send_byte(8'h11, 0);
    send_byte(8'h80, 0);
    chk("wr_ch.pre_commit", duty_g, 8'h00);
    send_byte(8'h91, 0);
    chk("wr_ch.update", update, 1'b1);
    chk("wr_ch.duty_g", duty_g, 8'h80);
    @(negedge clk);
    chk("wr_ch.update_one_cycle", update, 1'b0);
    window_end();
    check_all("wr_ch");

    // write all channels, all change on the same edge
    window_begin();
    send_list('{8'h20, 8'h10, 8'h20, 8'h30, 8'h40});
    chk("wr_all.pre_commit", {duty_r, duty_g, duty_b, duty_w}, 32'h0080_0000);
    send_byte(8'h60, 0);
    chk("wr_all.update", update, 1'b1);
    chk("wr_all.duties", {duty_r, duty_g, duty_b, duty_w}, 32'h1020_3040);
    window_end();
    check_all("wr_all");

    // bad checksum on intensity write
    window_begin();
    send_list('{8'h30, 8'h55, 8'h00});
    chk("bad_cks.frame_err", frame_err, 1'b1);
    chk("bad_cks.update", update, 1'b0);
    window_end();
    check_all("bad_cks");

    // bad opcode flagged one edge after the command byte
    window_begin();
    send_byte(8'h70, 0);
    chk("bad_op.frame_err", frame_err, 1'b1);
    send_byte(8'h12, 0);
    window_end();
    check_all("bad_op");

    // aborted frame: no commit, no error
    window_begin();
    send_list('{8'h20, 8'h01});
    window_end();
    check_all("abort");

    // checksum strobed in the same cycle cs rises is ignored
    window_begin();
    send_list('{8'h10, 8'h05});
    @(negedge clk);
    cs         = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h15;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_window();
    win.delete();
    check_all("cs_prio");

    // intensity write so the reset check sees a change
    window_begin();
    send_list('{8'h30, 8'h12, 8'h22});
    window_end();
    check_all("wr_int");

    // asynchronous reset mid-frame
    window_begin();
    send_list('{8'h20, 8'hAA});
    #2;
    reset = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) exp_duty[c] = 8'h00;
    exp_int = 8'hFF;
    win.delete();
    chk("async_rst.duties", {duty_r, duty_g, duty_b, duty_w}, 32'h0);
    chk("async_rst.intensity", intensity, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    // cs still low from before reset: no falling edge, frame must be ignored
    send_list('{8'h13, 8'h7F, 8'h6C});
    win.delete();
    window_end();
    check_all("no_fresh_cs");
    window_begin();
    send_list('{8'h13, 8'h7F, 8'h6C});
    window_end();
    check_all("post_rst");
    chk("post_rst.duty_w", duty_w, 8'h7F);

    // trailing frame in the same window is dropped
    window_begin();
    send_list('{8'h10, 8'h05, 8'h15, 8'h10, 8'h09, 8'h19});
    window_end();
    check_all("trailing");
    chk("trailing.duty_r", duty_r, 8'h05);

    // random frames
    for (int n = 0; n < 30; n++) begin
      fr.delete();
      kind = $urandom_range(0, 5);
      if (kind == 4) begin
        v  = $urandom_range(0, 12);
        op = (v == 0) ? 4'h0 : 4'(v + 3);
        fr.push_back({op, 4'($urandom)});
        repeat ($urandom_range(0, 3)) fr.push_back(8'($urandom));
      end else begin
        op = (kind < 3) ? 4'(kind + 1) : 4'($urandom_range(1, 3));
        fr.push_back({op, 4'($urandom)});
        repeat ((op == 4'h2) ? 4 : 1) fr.push_back(8'($urandom));
        x = 8'h00;
        foreach (fr[i]) x ^= fr[i];
        if (kind == 3) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
        if (kind == 5) begin
          repeat ($urandom_range(1, 3)) void'(fr.pop_back());
        end else if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 4)) fr.push_back(8'($urandom));
        end
      end
      window_begin();
      foreach (fr[i]) send_byte(fr[i], $urandom_range(0, 2));
      window_end();
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
